// File: rtl/expr_equiv_checker_if.sv
// expr_equiv_checker_if: sweep control, expression stimulus/response and result bus.
interface expr_equiv_checker_if #(parameter int N = 3);
  logic         start;
  logic [N-1:0] vec;
  logic         orig_in;
  logic         simp_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   mismatch_count;
  logic [N-1:0] first_bad_vec;
  logic         first_bad_valid;
  modport master (output start, orig_in, simp_in,
                  input vec, busy, done, pass, mismatch_count, first_bad_vec, first_bad_valid);
  modport slave (input start, orig_in, simp_in,
                 output vec, busy, done, pass, mismatch_count, first_bad_vec, first_bad_valid);
endinterface

// File: rtl/expr_equiv_checker.sv
// expr_equiv_checker: exhaustive sweep comparing an original and a simplified boolean expression.
module expr_equiv_checker #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  expr_equiv_checker_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t              r_state;
  logic [N_INPUTS-1:0] r_vec;
  logic [N_INPUTS-1:0] r_first;
  logic [N_INPUTS:0]   r_mc;
  logic [CW-1:0]       r_sc;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_valid;
  logic                w_mis;
  logic                w_last;
  logic [N_INPUTS:0]   w_mc_next;
  assign w_mis     = bus.orig_in ^ bus.simp_in;
  assign w_last    = &r_vec;
  assign w_mc_next = r_mc + (N_INPUTS + 1)'(w_mis);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_first <= '0;
      r_mc    <= '0;
      r_sc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (bus.start) begin
          r_state <= SETTLE;
          r_vec   <= '0;
          r_first <= '0;
          r_mc    <= '0;
          r_sc    <= CW'(SETTLE_CYCLES);
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
          r_valid <= 1'b0;
        end
        SETTLE: begin
          r_sc <= r_sc - CW'(1);
          if (r_sc == CW'(1)) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_mc <= w_mc_next;
          if (w_mis && !r_valid) begin
            r_first <= r_vec;
            r_valid <= 1'b1;
          end
          // terminal vector detected by all-ones compare so vec never wraps
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_mc_next == '0;
          end else begin
            r_state <= SETTLE;
            r_vec   <= r_vec + N_INPUTS'(1);
            r_sc    <= CW'(SETTLE_CYCLES);
          end
        end
      endcase
    end
  end
  assign bus.vec             = r_vec;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.mismatch_count  = r_mc;
  assign bus.first_bad_vec   = r_first;
  assign bus.first_bad_valid = r_valid;
endmodule

// File: doc/expr_equiv_checker.md
# expr_equiv_checker

Hardware sweep controller for a pair of N-input combinational boolean expressions (an original form and its simplified form). On `start` it drives every input vector 0 .. 2^N-1 onto the shared expression inputs and waits a programmable settle time. It then compares the two expression outputs, counts the mismatches and captures the first failing vector. It sits between the original/simplified expression instances and the system/bench control, replacing open-loop exhaustive stimulus with a self-checking sequencer.

## Interface
Parameters:
- `N_INPUTS`, default 3: number of expression inputs, range 1..16.
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling, minimum 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a sweep; sampled only in IDLE or DONE.
- `vec` output N_INPUTS: input vector driven to both expressions, MSB = first input (A).
- `orig_in` input 1: output of the original expression.
- `simp_in` input 1: output of the simplified expression.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: level; high from sweep completion until the next accepted `start` or `rst`.
- `pass` output 1: valid when `done`=1; 1 if `mismatch_count`==0.
- `mismatch_count` output N_INPUTS+1: number of vectors where `orig_in`≠`simp_in`.
- `first_bad_vec` output N_INPUTS: vector of the first mismatch.
- `first_bad_valid` output 1: `first_bad_vec` holds a captured vector.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `vec`=0; outputs held at reset values.
  - `start`=1 → clear the statistics, `vec`=0, load the settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle; `vec` stable.
  - Counter reaches 0 after SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE (one cycle):
  - Compare `orig_in` and `simp_in`.
  - On mismatch, `mismatch_count`+1. If `first_bad_valid`=0, capture `first_bad_vec`=`vec` and set `first_bad_valid`=1.
  - If `vec`==2^N-1 → DONE. Otherwise `vec`+1, reload the counter → SETTLE.
- DONE:
  - `done`=1, `pass` driven, statistics held, `vec` holds its last value (2^N-1).
  - `start`=1 → same restart action as from IDLE.
- `start` in SETTLE or SAMPLE is ignored; it is not queued.
- `vec` increments without wrap; terminal detection uses the all-ones compare, not the carry.
- `mismatch_count` is N_INPUTS+1 bits wide, so 2^N mismatches fit with no saturation logic.
- The inputs `orig_in` and `simp_in` are combinational functions of `vec`. They are not registered before the compare.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `pass`=0, `mismatch_count`=0, `first_bad_vec`=0, `first_bad_valid`=0, state IDLE.
- `rst` wins over every other event, including `start` in the same cycle. An assertion mid-sweep aborts it and returns all outputs to their reset values on the next edge.
- Sequence from an accepted `start` at edge k:
  - `busy`=1 and `vec`=0 from edge k+1.
  - Each vector is held SETTLE_CYCLES+1 cycles; the compare happens in the last of them.
  - `busy` stays high for exactly 2^N·(SETTLE_CYCLES+1) cycles.
  - `done`=1 and `busy`=0 from the edge after the final SAMPLE.
- `busy` and `done` are never both high.
- A restart from DONE drops `done`, clears the statistics and raises `busy` on the same edge.
- With defaults (N=3, S=1), `busy` lasts 16 cycles.

## Test plan
- Equivalent expressions (`orig_in` = `simp_in` = A&B | A&C, driven from `vec`), defaults → `busy` for 16 cycles, then `done`=1, `pass`=1, `mismatch_count`=0, `first_bad_valid`=0.
- `simp_in` = ~`orig_in` → `mismatch_count`=8, `first_bad_vec`=3'b000, `first_bad_valid`=1, `pass`=0.
- Expressions differing only at `vec`=5 → `mismatch_count`=1, `first_bad_vec`=3'b101, `pass`=0.
- Second `start` pulse in cycle 6 of `busy` → ignored; `done` still rises after exactly 16 `busy` cycles with correct statistics.
- `rst` asserted in cycle 10 of a failing sweep → next edge: all outputs at reset values, state IDLE. A new `start` gives a full, correct 16-cycle sweep.
- SETTLE_CYCLES=3, N_INPUTS=4, identical expressions → `busy` for 64 cycles, `pass`=1. A restart from DONE clears the statistics and repeats the result.
